multiplexer_n_to_1_registered: RTL and testbench
================================================

Name: multiplexer_n_to_1_registered

Overview:
Parametrised N-to-1 data multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output. It has two modes: direct select from select lines, and round-robin scan across channels. It sits between several producer channels and a single consumer. It is the sequential, width- and channel-generalised successor of the gate-level 4-to-1 selector.

Parameters:
CHANNELS, 4, number of input channels (2..16)
DATA_WIDTH, 8, bits per channel
SEL_WIDTH, 2, select/channel-index width; must satisfy 2**SEL_WIDTH >= CHANNELS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
mode  input  1  0 = direct select, 1 = round-robin
select_lines  input  SEL_WIDTH  channel index used when mode = 0
input_lines  input  CHANNELS*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
input_valid  input  CHANNELS  per-channel data valid
input_ready  output  CHANNELS  per-channel accept, at most one bit set
out  output  DATA_WIDTH  registered selected data
out_valid  output  1  out holds an accepted word
out_ready  input  1  consumer accepts out this cycle
out_channel  output  SEL_WIDTH  index of the channel that produced out
sel_error  output  1  one-cycle pulse: select_lines >= CHANNELS while loading in mode 0

Behaviour:
- One clock, one register stage; all state updates on rising clk edge.
- Reset (rst_n = 0 at an edge): out = 0, out_valid = 0, out_channel = 0, sel_error = 0, rr_ptr = 0. input_ready = 0 combinationally while rst_n = 0.
- Reset mid-transfer discards the held word; no handshake completes in the reset cycle.
- Output FSM, encoded by out_valid:
  - EMPTY (out_valid = 0)
  - FULL (out_valid = 1)
- load = !out_valid || out_ready. When load = 0 (FULL and stalled): out, out_valid and out_channel hold; input_ready = 0.
- Mode 0, load = 1, c = select_lines:
  - c < CHANNELS and input_valid[c] = 1: input_ready[c] = 1; next edge out <= channel c data, out_channel <= c, out_valid <= 1.
  - c < CHANNELS and input_valid[c] = 0: no grant; out_valid <= 0.
  - c >= CHANNELS: no grant; out_valid <= 0; sel_error <= 1 for one cycle.
- Mode 1, load = 1: search channels rr_ptr, rr_ptr+1, ... modulo CHANNELS; the first with input_valid set is c.
  - Grant as in mode 0, then rr_ptr <= (c+1) mod CHANNELS. Wrap from CHANNELS-1 goes to 0, also for non-power-of-2 CHANNELS.
  - No valid channel: out_valid <= 0, rr_ptr unchanged.
  - select_lines ignored; sel_error stays 0.
- sel_error is 0 in every cycle not covered above.
- Latency: accepted word appears on out one cycle after its input_ready/input_valid handshake.
- Throughput: one word per cycle when out_ready is held 1.
- Simultaneous out_ready = 1 and a new grant in FULL: old word retires and new word loads on the same edge, giving back-to-back valid.
- input_ready is combinational from mode, select_lines, input_valid, rr_ptr, out_valid and out_ready. It never depends on input_lines.
- Mode or select change takes effect at the next load cycle. rr_ptr is retained across mode switches.
- Producers must hold data stable while valid and not ready. The block never drops an asserted word that it granted.

Optional Feature:
MUX_PARITY_EN
- Defined: adds output out_parity (1 bit), registered with out, equal to the even parity (XOR reduction) of the loaded word. Reset value 0; holds during stall.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, CHANNELS = 4, DATA_WIDTH = 4, input_lines = {4'hD, 4'hC, 4'hB, 4'hA}, all valid, out_ready = 1, select 0..3 on successive cycles -> out = A, B, C, D one cycle later each; out_channel = 0..3; out_valid continuous.
- Mode 1, all 4 valid, out_ready = 1 for 6 cycles -> out_channel 0, 1, 2, 3, 0, 1; input_ready one-hot rotating.
- Mode 1, only channel 2 valid, then only channel 1 -> grant 2 (rr_ptr = 3), then 1 after wrap (rr_ptr = 2).
- Backpressure: out FULL with 0xA, out_ready = 0 for 3 cycles -> out = 0xA, out_valid = 1 held; input_ready = 0; on release the next word loads on the same edge.
- CHANNELS = 3, mode 0, select_lines = 3 -> sel_error pulses 1 cycle, out_valid = 0, input_ready = 0.
- rst_n = 0 while FULL and out_ready = 0 -> next edge out = 0, out_valid = 0, rr_ptr = 0; first grant after release goes to channel 0 in mode 1.

Source files
------------

// File: rtl/multiplexer_n_to_1_registered.sv
// Registered N-to-1 multiplexer with valid/ready handshakes, direct-select and round-robin modes.
// Optional MUX_PARITY_EN adds a registered even-parity bit (out_parity) alongside out.
module multiplexer_n_to_1_registered #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode,
  input  logic [SEL_WIDTH-1:0]           select_lines,
  input  logic [CHANNELS*DATA_WIDTH-1:0] input_lines,
  input  logic [CHANNELS-1:0]            input_valid,
  output logic [CHANNELS-1:0]            input_ready,
  output logic [DATA_WIDTH-1:0]          out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SEL_WIDTH-1:0]           out_channel,
  output logic                           sel_error
`ifdef MUX_PARITY_EN
  ,
  output logic                           out_parity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [SEL_WIDTH-1:0]  rr_ptr, rr_next;
  logic [SEL_WIDTH-1:0]  grant_ch;
  logic                  grant;
  logic                  load;
  logic                  sel_bad;
  logic                  found;
  int                    idx;
  int                    nxt;
  logic [DATA_WIDTH-1:0] grant_data;

  assign out_valid  = (state == FULL);
  assign grant_data = input_lines[int'(grant_ch)*DATA_WIDTH +: DATA_WIDTH];

  // Arbitration: a grant is only issued when the output register can take a word.
  always_comb begin
    state_next  = state;
    rr_next     = rr_ptr;
    grant       = 1'b0;
    grant_ch    = '0;
    sel_bad     = 1'b0;
    found       = 1'b0;
    idx         = 0;
    nxt         = 0;
    input_ready = '0;
    load        = (state == EMPTY) || out_ready;

    if (rst_n && load) begin
      if (!mode) begin
        if (int'(select_lines) < CHANNELS) begin
          if (input_valid[select_lines]) begin
            grant    = 1'b1;
            grant_ch = select_lines;
          end
        end else begin
          sel_bad = 1'b1;
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          idx = int'(rr_ptr) + i;
          if (idx >= CHANNELS) idx = idx - CHANNELS;
          if (!found && input_valid[idx]) begin
            found    = 1'b1;
            grant_ch = SEL_WIDTH'(idx);
          end
        end
        if (found) begin
          grant = 1'b1;
          nxt   = int'(grant_ch) + 1;
          if (nxt >= CHANNELS) nxt = 0;
          rr_next = SEL_WIDTH'(nxt);
        end
      end
      state_next = grant ? FULL : EMPTY;
    end

    if (grant) input_ready[grant_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out         <= '0;
      out_channel <= '0;
      sel_error   <= 1'b0;
      rr_ptr      <= '0;
`ifdef MUX_PARITY_EN
      out_parity  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      sel_error <= sel_bad;
      rr_ptr    <= rr_next;
      if (grant) begin
        out         <= grant_data;
        out_channel <= grant_ch;
`ifdef MUX_PARITY_EN
        out_parity  <= ^grant_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_n_to_1_registered.sv
// Bench for multiplexer_n_to_1_registered: a 4-channel table-driven run plus a 3-channel instance
// for out-of-range select and non-power-of-2 wrap; also checks out_parity when MUX_PARITY_EN is set.
module tb_multiplexer_n_to_1_registered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  select_lines;
  logic [15:0] input_lines;
  logic [3:0]  input_valid;
  logic [3:0]  input_ready;
  logic [3:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_channel;
  logic        sel_error;

  logic        mode3;
  logic [1:0]  select3;
  logic [11:0] lines3;
  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic [3:0]  out3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_channel3;
  logic        sel_error3;

`ifdef MUX_PARITY_EN
  logic        out_parity;
  logic        out_parity3;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  multiplexer_n_to_1_registered #(.CHANNELS(4), .DATA_WIDTH(4), .SEL_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .select_lines(select_lines),
    .input_lines(input_lines), .input_valid(input_valid), .input_ready(input_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_channel(out_channel), .sel_error(sel_error)
`ifdef MUX_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  multiplexer_n_to_1_registered #(.CHANNELS(3), .DATA_WIDTH(4), .SEL_WIDTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .select_lines(select3),
    .input_lines(lines3), .input_valid(valid3), .input_ready(ready3),
    .out(out3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_channel(out_channel3), .sel_error(sel_error3)
`ifdef MUX_PARITY_EN
    , .out_parity(out_parity3)
`endif
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic [3:0] exp_out;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic       exp_err;
  } vec_t;

  vec_t vecs[20];

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic r);
    mode         = m;
    select_lines = s;
    input_valid  = v;
    out_ready    = r;
  endtask

  task automatic apply3(input logic m, input logic [1:0] s, input logic [2:0] v);
    mode3      = m;
    select3    = s;
    valid3     = v;
    out_ready3 = 1'b1;
  endtask

  task automatic check3(input int idx, input logic [2:0] rdy, input logic [3:0] o,
                        input logic ov, input logic [1:0] ch, input logic err);
    checkOutput("c3_ready", idx, 32'(ready3), 32'(rdy));
    @(posedge clk); #1;
    checkOutput("c3_out_valid", idx, 32'(out_valid3), 32'(ov));
    if (ov) begin
      checkOutput("c3_out", idx, 32'(out3), 32'(o));
      checkOutput("c3_channel", idx, 32'(out_channel3), 32'(ch));
    end
    checkOutput("c3_sel_error", idx, 32'(sel_error3), 32'(err));
  endtask

  initial begin
    //                mode  sel   valid  ordy  ready    out   ov    ch    err
    // Direct select, then an invalid selected channel.
    vecs[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 4'hC, 1'b1, 2'd2, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 4'hD, 1'b1, 4'b0000, 4'hD, 1'b0, 2'd3, 1'b0};
    // Round-robin, all valid: pointer starts at 0 since mode 0 never moves it.
    vecs[5]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b0100, 4'hC, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 4'hF, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0};
    // Pointer is 2: only ch2, then only ch1 (wraps 3,0,1), idle, then ch3.
    vecs[11] = '{1'b1, 2'd0, 4'h4, 1'b1, 4'b0100, 4'hC, 1'b1, 2'd2, 1'b0};
    vecs[12] = '{1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0};
    vecs[13] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 4'hB, 1'b0, 2'd1, 1'b0};
    vecs[14] = '{1'b1, 2'd0, 4'h8, 1'b1, 4'b1000, 4'hD, 1'b1, 2'd3, 1'b0};
    // Backpressure: hold A for three stalled cycles, then B loads on release.
    vecs[15] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 4'hA, 1'b1, 2'd0, 1'b0};
    vecs[19] = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 4'hB, 1'b1, 2'd1, 1'b0};

    input_lines = 16'hDCBA;
    lines3      = 12'hCBA;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'hF, 1'b1);
    apply3(1'b0, 2'd0, 3'b111);
    #1;
    checkOutput("ready_in_reset", 0, 32'(input_ready), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_out", 0, 32'(out), 32'h0);
    checkOutput("reset_out_valid", 0, 32'(out_valid), 32'h0);
    checkOutput("reset_channel", 0, 32'(out_channel), 32'h0);
    checkOutput("reset_sel_error", 0, 32'(sel_error), 32'h0);
    checkOutput("c3_reset_out_valid", 0, 32'(out_valid3), 32'h0);
`ifdef MUX_PARITY_EN
    checkOutput("reset_parity", 0, 32'(out_parity), 32'h0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy);
      #1;
      checkOutput("input_ready", i, 32'(input_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      checkOutput("out", i, 32'(out), 32'(vecs[i].exp_out));
      checkOutput("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
      checkOutput("out_channel", i, 32'(out_channel), 32'(vecs[i].exp_ch));
      checkOutput("sel_error", i, 32'(sel_error), 32'(vecs[i].exp_err));
`ifdef MUX_PARITY_EN
      checkOutput("out_parity", i, 32'(out_parity), 32'(^vecs[i].exp_out));
`endif
    end

    // Reset while FULL and stalled, with the round-robin pointer left at 3.
    applyStimulus(1'b1, 2'd0, 4'h4, 1'b1);
    @(posedge clk); #1;
    checkOutput("pre_reset_out", 30, 32'(out), 32'hC);
    applyStimulus(1'b1, 2'd0, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("ready_in_reset", 31, 32'(input_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("reset_out", 31, 32'(out), 32'h0);
    checkOutput("reset_out_valid", 31, 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
    #1;
    checkOutput("post_reset_ready", 32, 32'(input_ready), 32'b0001);
    @(posedge clk); #1;
    checkOutput("post_reset_channel", 32, 32'(out_channel), 32'h0);
    checkOutput("post_reset_out", 32, 32'(out), 32'hA);

    // Three channels: out-of-range select, then round-robin wrap from channel 2 to 0.
    apply3(1'b0, 2'd2, 3'b111); #1; check3(40, 3'b100, 4'hC, 1'b1, 2'd2, 1'b0);
    apply3(1'b0, 2'd3, 3'b111); #1; check3(41, 3'b000, 4'hC, 1'b0, 2'd2, 1'b1);
    apply3(1'b0, 2'd0, 3'b111); #1; check3(42, 3'b001, 4'hA, 1'b1, 2'd0, 1'b0);
    apply3(1'b1, 2'd3, 3'b111); #1; check3(43, 3'b001, 4'hA, 1'b1, 2'd0, 1'b0);
    apply3(1'b1, 2'd3, 3'b100); #1; check3(44, 3'b100, 4'hC, 1'b1, 2'd2, 1'b0);
    apply3(1'b1, 2'd3, 3'b011); #1; check3(45, 3'b001, 4'hA, 1'b1, 2'd0, 1'b0);
    apply3(1'b1, 2'd3, 3'b110); #1; check3(46, 3'b010, 4'hB, 1'b1, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
